regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (RegWrite/WA/WD) between the main
//  pipeline writeback (primary, never stalled by this block) and a long-latency
//  unit such as the multi-cycle MLA/load path (secondary, valid/ready).
//  Buffers secondary writes in a small FIFO, drains them in idle primary slots,
//  forces a pipeline bubble on starvation and flags read hazards on buffered
//  registers to decode.
// PARAMETERS
//  DEPTH        2  secondary FIFO entries; power of 2, >= 2
//  STARVE_LIMIT 4  consecutive blocked cycles before stall_req asserts; >= 1
// PORTS
//  clk        in   1   single clock, rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  p_we       in   1   primary write request this cycle
//  p_wa       in   4   primary write address
//  p_wd       in   32  primary write data
//  s_valid    in   1   secondary write request
//  s_ready    out  1   secondary accept (= FIFO not full)
//  s_wa       in   4   secondary write address
//  s_wd       in   32  secondary write data
//  wr_en      out  1   to RegWrite, registered
//  wr_addr    out  4   to WA, registered
//  wr_data    out  32  to WD, registered
//  chk_en     in   1   decode hazard check enable
//  chk_ra1    in   4   decode read address 1
//  chk_ra2    in   4   decode read address 2
//  chk_ra3    in   4   decode read address 3 (Ra of MLA)
//  pending_hit out 1   combinational: a chk_ra* matches a not-yet-written write
//  stall_req  out  1   registered: pipeline must drive p_we=0 next cycle
// BEHAVIOUR
//  Reset (async assert, sync-safe release): FIFO empty, wr_en=0, wr_addr=0,
//   wr_data=0, stall_req=0, starve counter=0; s_ready=1. Buffered entries lost.
//  Push: s_valid && s_ready at an edge -> entry appended. No bypass: an entry
//   is never written the same cycle it is accepted. s_ready is !full only; a
//   pop in the same cycle does not raise s_ready when full.
//  Each edge, output register loads exactly one source:
//   p_we=1           -> wr_en=1, wr_addr=p_wa, wr_data=p_wd (primary wins)
//   p_we=0, FIFO !empty -> pop head; wr_en=1 with head addr/data
//   else             -> wr_en=0 (wr_addr/wr_data hold)
//  Latency: primary 1 cycle (p_we at edge T -> wr_en high in cycle after T).
//   Secondary min 2 cycles (accepted at T, popped at T+1, visible after T+1).
//  FIFO strictly in order; pointers wrap modulo DEPTH; simultaneous push+pop
//   when not full keeps occupancy constant.
//  Starve counter: +1 (saturating at STARVE_LIMIT) each edge where FIFO !empty
//   and p_we=1; cleared on any pop or when FIFO empty. stall_req register loads
//   (counter_next == STARVE_LIMIT). If the pipeline ignores stall_req, primary
//   still wins and stall_req stays high until a pop occurs.
//  pending_hit = chk_en && (any chk_ra* equals addr of: a valid FIFO entry, the
//   output stage when wr_en=1, or s_wa when s_valid && s_ready). Matching p_wa
//   is decode's forwarding concern, not flagged here.
//  WAW: p_we with p_wa equal to a buffered entry's address is a protocol error
//   (decode must stall on pending_hit); the block does not reorder or drop.
// TESTING
//  p_we=1,p_wa=3,p_wd=0xDEADBEEF, FIFO empty -> next cycle wr_en=1,wr_addr=3,
//   wr_data=0xDEADBEEF; s_ready stays 1.
//  Idle primary; s_valid 1 cycle, s_wa=5,s_wd=0x12 -> wr_en=1,wr_addr=5,
//   wr_data=0x12 exactly 2 cycles after acceptance, then wr_en=0.
//  p_we=1 every cycle; push wa=1 then wa=2 -> s_ready=0 when full; stall_req=1
//   after 4 blocked edges; drop p_we -> writes addr 1 then 2; stall_req=0.
//  Entry wa=7 buffered, chk_en=1, chk_ra2=7 -> pending_hit=1 until cycle after
//   wr_en with wr_addr=7; chk_en=0 -> pending_hit=0.
//  Full FIFO, p_we=0, s_valid=1 -> s_ready=0 that cycle, one pop; next cycle
//   s_ready=1 and push accepted.
//  2 entries buffered, reset_n low mid-drain -> wr_en=0, stall_req=0, s_ready=1
//   immediately; after release no write of the lost entries ever occurs.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter. The primary writeback always wins the port.
// Secondary writes wait in a small in-order FIFO, with starvation stall and hazard flagging.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_we,
  input  logic [3:0]  p_wa,
  input  logic [31:0] p_wd,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  s_wa,
  input  logic [31:0] s_wd,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic        chk_en,
  input  logic [3:0]  chk_ra1,
  input  logic [3:0]  chk_ra2,
  input  logic [3:0]  chk_ra3,
  output logic        pending_hit,
  output logic        stall_req
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

  logic [3:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;
  logic [SC_W-1:0]  starve_next;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             buf_hit;

  function automatic logic addr_match(input logic [3:0] a,
                                      input logic [3:0] r1,
                                      input logic [3:0] r2,
                                      input logic [3:0] r3);
    return (a == r1) || (a == r2) || (a == r3);
  endfunction

  // s_ready depends on occupancy only, so a same-cycle pop never admits a push into a full FIFO.
  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign s_ready = !full;
  assign push    = s_valid && s_ready;
  assign pop     = !p_we && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s_wa;
      fifo_data[wr_ptr] <= s_wd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Only a cycle where the primary blocks a non-empty FIFO extends the starve run.
  always_comb begin
    starve_next = '0;
    if (!empty && p_we) begin
      starve_next = (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == STARVE_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (p_we) begin
      wr_en   <= 1'b1;
      wr_addr <= p_wa;
      wr_data <= p_wd;
    end else if (!empty) begin
      wr_en   <= 1'b1;
      wr_addr <= fifo_addr[rd_ptr];
      wr_data <= fifo_data[rd_ptr];
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Slots beyond the occupancy may hold stale addresses and must not raise a hazard.
  always_comb begin
    buf_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) begin
        if (addr_match(fifo_addr[rd_ptr + PTR_W'(k)], chk_ra1, chk_ra2, chk_ra3)) begin
          buf_hit = 1'b1;
        end
      end
    end
  end

  assign pending_hit = chk_en &&
                       (buf_hit ||
                        (wr_en && addr_match(wr_addr, chk_ra1, chk_ra2, chk_ra3)) ||
                        (push  && addr_match(s_wa,    chk_ra1, chk_ra2, chk_ra3)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Expected values are hand-computed for DEPTH=2 and STARVE_LIMIT=4.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        p_we;
  logic [3:0]  p_wa;
  logic [31:0] p_wd;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_wa;
  logic [31:0] s_wd;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        chk_en;
  logic [3:0]  chk_ra1;
  logic [3:0]  chk_ra2;
  logic [3:0]  chk_ra3;
  logic        pending_hit;
  logic        stall_req;

  int num_compared;
  int num_mismatched;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_we(p_we), .p_wa(p_wa), .p_wd(p_wd),
    .s_valid(s_valid), .s_ready(s_ready), .s_wa(s_wa), .s_wd(s_wd),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .chk_en(chk_en), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_ra3(chk_ra3),
    .pending_hit(pending_hit), .stall_req(stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pwe, input logic [3:0] pwa, input logic [31:0] pwd,
                               input logic sv, input logic [3:0] swa, input logic [31:0] swd);
    p_we    = pwe;
    p_wa    = pwa;
    p_wd    = pwd;
    s_valid = sv;
    s_wa    = swa;
    s_wd    = swd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    num_compared   = 0;
    num_mismatched = 0;
    reset_n = 1'b0;
    chk_en  = 1'b0;
    chk_ra1 = '0;
    chk_ra2 = '0;
    chk_ra3 = '0;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #12;
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_stall", stall_req, 0);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_pending", pending_hit, 0);
    reset_n = 1'b1;
    tick();

    // primary write, one cycle latency
    applyStimulus(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("prim_wr_en", wr_en, 1);
    checkOutput("prim_wr_addr", wr_addr, 3);
    checkOutput("prim_wr_data", wr_data, 32'hDEADBEEF);
    checkOutput("prim_s_ready", s_ready, 1);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("idle_wr_en", wr_en, 0);
    checkOutput("idle_addr_hold", wr_addr, 3);

    // secondary write, two cycle latency
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h12);
    #1;
    checkOutput("sec_s_ready", s_ready, 1);
    tick();
    checkOutput("sec_no_bypass", wr_en, 0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("sec_wr_en", wr_en, 1);
    checkOutput("sec_wr_addr", wr_addr, 5);
    checkOutput("sec_wr_data", wr_data, 32'h12);
    tick();
    checkOutput("sec_done", wr_en, 0);

    // starvation: primary busy while FIFO fills
    applyStimulus(1'b1, 4'd9, 32'h99, 1'b1, 4'd1, 32'h111);
    tick();
    checkOutput("starve_ready1", s_ready, 1);
    applyStimulus(1'b1, 4'd9, 32'h99, 1'b1, 4'd2, 32'h222);
    tick();
    checkOutput("starve_full", s_ready, 0);
    checkOutput("starve_stall_e2", stall_req, 0);
    applyStimulus(1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'd0);
    tick();
    tick();
    checkOutput("starve_stall_e4", stall_req, 0);
    checkOutput("starve_prim_addr", wr_addr, 9);
    tick();
    checkOutput("starve_stall_e5", stall_req, 1);
    tick();
    checkOutput("starve_stall_sat", stall_req, 1);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("drain1_wr_en", wr_en, 1);
    checkOutput("drain1_addr", wr_addr, 1);
    checkOutput("drain1_data", wr_data, 32'h111);
    checkOutput("drain1_stall", stall_req, 0);
    tick();
    checkOutput("drain2_addr", wr_addr, 2);
    checkOutput("drain2_data", wr_data, 32'h222);
    checkOutput("drain2_ready", s_ready, 1);
    tick();
    checkOutput("drain_done", wr_en, 0);

    // hazard flag on buffered address 7
    chk_ra1 = 4'd15;
    chk_ra2 = 4'd7;
    chk_ra3 = 4'd14;
    chk_en  = 1'b1;
    #1;
    checkOutput("haz_none", pending_hit, 0);
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd7, 32'h77);
    #1;
    checkOutput("haz_incoming", pending_hit, 1);
    tick();
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
    #1;
    checkOutput("haz_buffered", pending_hit, 1);
    tick();
    checkOutput("haz_buffered2", pending_hit, 1);
    chk_en = 1'b0;
    #1;
    checkOutput("haz_disabled", pending_hit, 0);
    chk_en = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("haz_out_addr", wr_addr, 7);
    checkOutput("haz_out_stage", pending_hit, 1);
    tick();
    checkOutput("haz_cleared", pending_hit, 0);
    chk_en  = 1'b0;
    chk_ra1 = '0;
    chk_ra2 = '0;
    chk_ra3 = '0;

    // full FIFO: a pop does not admit the same-cycle push
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd10, 32'hA0);
    tick();
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd11, 32'hB0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b1, 4'd12, 32'hC0);
    #1;
    checkOutput("full_not_ready", s_ready, 0);
    tick();
    checkOutput("full_pop_addr", wr_addr, 10);
    checkOutput("full_ready_after", s_ready, 1);
    tick();
    checkOutput("full_pop2_addr", wr_addr, 11);
    checkOutput("full_pop2_data", wr_data, 32'hB0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checkOutput("full_late_addr", wr_addr, 12);
    checkOutput("full_late_data", wr_data, 32'hC0);
    tick();
    checkOutput("full_done", wr_en, 0);

    // reset while two entries are buffered and stall is raised
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd13, 32'hD0);
    tick();
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b1, 4'd14, 32'hE0);
    tick();
    applyStimulus(1'b1, 4'd4, 32'h44, 1'b0, 4'd0, 32'd0);
    tick();
    tick();
    tick();
    checkOutput("pre_rst_stall", stall_req, 1);
    checkOutput("pre_rst_ready", s_ready, 0);
    checkOutput("pre_rst_wr_en", wr_en, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", wr_en, 0);
    checkOutput("mid_rst_stall", stall_req, 0);
    checkOutput("mid_rst_ready", s_ready, 1);
    checkOutput("mid_rst_addr", wr_addr, 0);
    applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("post_rst_no_write", wr_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
